sid_bus_queue: RTL and testbench
================================

Name: sid_bus_queue

Overview:
- Sits between the SPI slave and the SID core.
- Decodes the two-byte SPI write protocol into SID register writes and buffers them in a FIFO.
- Issues at most one write per SID 1 MHz clock enable, so SPI bursts never collide with or outrun the SID bus.
- Reports FIFO level plus sticky overflow and framing-error flags.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2.
LVL_W, 5, width of oLevel; must equal log2(DEPTH)+1.

Ports:
clk  input  1  system clock (12 MHz).
rst  input  1  synchronous reset, active-high.
iSpiData  input  8  byte from SPI slave; valid when iSpiRecv=1.
iSpiRecv  input  1  single-cycle strobe: byte received.
iClkEn  input  1  SID 1 MHz clock enable, 1 cycle in 12.
oWE  output  1  SID write strobe, single-cycle pulse.
oAddr  output  5  SID register address.
oDataW  output  8  SID write data.
oLevel  output  LVL_W  current FIFO occupancy, 0..DEPTH.
oOverflow  output  1  sticky: a write was dropped because the FIFO was full.
oFrameErr  output  1  sticky: a data byte arrived with no prior header.

Behaviour:

Reset (synchronous, rst=1 at a clk edge):
- oWE=0, oAddr=0, oDataW=0, oLevel=0, oOverflow=0, oFrameErr=0.
- FIFO emptied; header-valid flag cleared.
- rst overrides every other input that cycle. Any in-progress write is abandoned.

Decoder (acts only on cycles with iSpiRecv=1):
- Header byte (bit7=1):
  - latch hdrAddr=iSpiData[6:2] and hdrMsb=iSpiData[1:0]
  - set hdrValid
  - no push
  - a second header simply overwrites the latched values.
- Data byte (bit7=0), hdrValid=1:
  - push entry {hdrAddr, hdrMsb, iSpiData[5:0]}
  - iSpiData[6] is ignored
  - hdrValid stays set, so further data bytes reuse the latched address and MSBs.
- Data byte (bit7=0), hdrValid=0: byte dropped, oFrameErr set.

FIFO:
- Circular buffer, DEPTH entries, read/write pointers wrap modulo DEPTH.
- Push lands at the edge ending the iSpiRecv cycle; oLevel reflects it the next cycle.
- Pop condition: iClkEn=1 and level>0, level evaluated before this cycle's push.
- A push into an empty FIFO cannot pop in the same cycle; the earliest pop is the next iClkEn.
- Simultaneous push and pop: both take effect, level unchanged.
- Push while level=DEPTH:
  - with a pop the same cycle: accepted, level stays DEPTH, no overflow
  - without a pop: entry dropped, oOverflow set, level stays DEPTH.
- Entries are popped in strict arrival order.

Output stage (registered):
- On a pop cycle: oAddr/oDataW load the popped entry and oWE=1 on the following cycle.
- oWE lasts exactly one cycle.
- oAddr/oDataW hold their value until the next pop.
- Latency: iSpiRecv data byte at cycle t, next iClkEn at cycle c>t, oWE at c+1.
- Writes are spaced at least 12 clk cycles apart (one per iClkEn).

Sticky flags:
- Cleared only by rst.
- oOverflow and oFrameErr may both be set.

Test Plan:
1. Single write: after rst, bytes 0x85 then 0x2A, iClkEn every 12 cycles -> exactly one oWE pulse, cycle after the next iClkEn, oAddr=1, oDataW=0x6A, oLevel back to 0.
2. Burst reuse: 0x85, then 0x01, 0x02, 0x03 back-to-back -> three oWE pulses on consecutive iClkEn periods (12 cycles apart), all oAddr=1, oDataW=0x41, 0x42, 0x43 in order.
3. Framing: after rst, byte 0x2A with no header -> no oWE, oLevel=0, oFrameErr=1 and remains 1; then 0xFC, 0x3F -> oAddr=31, oDataW=0x3F.
4. Overflow: iClkEn held 0, header plus 17 data bytes 0x00..0x10 -> oLevel=16, oOverflow=1; then release iClkEn -> exactly 16 writes, data 0x40..0x4F (hdrMsb=01), byte 0x10 never written.
5. Full with pop: FIFO at 16, data byte coincident with iClkEn -> push accepted, oLevel stays 16, oOverflow stays 0, new entry written last.
6. Reset mid-stream: rst while oLevel=5 and header latched -> next cycle oWE=0, oLevel=0, flags 0; a subsequent data byte without header sets oFrameErr and produces no write.

Source files
------------

// File: rtl/sid_bus_queue_if.sv
// SPI-byte input and SID write-bus output bundle for sid_bus_queue.
// The slave modport is the queue itself. The master modport is whatever feeds it and observes it.
interface sid_bus_queue_if #(
    parameter int LVL_W = 5
);
    logic [7:0]       iSpiData;
    logic             iSpiRecv;
    logic             iClkEn;
    logic             oWE;
    logic [4:0]       oAddr;
    logic [7:0]       oDataW;
    logic [LVL_W-1:0] oLevel;
    logic             oOverflow;
    logic             oFrameErr;

    modport master (
        output iSpiData, iSpiRecv, iClkEn,
        input  oWE, oAddr, oDataW, oLevel, oOverflow, oFrameErr
    );

    modport slave (
        input  iSpiData, iSpiRecv, iClkEn,
        output oWE, oAddr, oDataW, oLevel, oOverflow, oFrameErr
    );
endinterface

// File: rtl/sid_bus_queue.sv
// Decodes two-byte SPI writes into SID register writes and queues them in a FIFO.
// The queue issues at most one write per SID clock enable.
module sid_bus_queue #(
    parameter int DEPTH = 16,
    parameter int LVL_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    sid_bus_queue_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (1 << AW) != DEPTH || LVL_W != AW + 1) begin : g_param_chk
        $error("sid_bus_queue: DEPTH must be a power of two >= 2 and LVL_W = log2(DEPTH)+1");
    end

    typedef struct packed {
        logic [4:0] addr;
        logic [7:0] data;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           wr_entry;
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;

    logic       hdr_valid;
    logic [4:0] hdr_addr;
    logic [1:0] hdr_msb;

    logic is_hdr, is_data, push_req, empty, full, pop, push, drop, frame_err;

    logic       we_q, ovf_q, ferr_q;
    logic [4:0] addr_q;
    logic [7:0] data_q;

    // Pop is decided on the level before this cycle's push.
    // A byte landing in an empty FIFO therefore waits for the next enable.
    always_comb begin
        is_hdr    = bus.iSpiRecv & bus.iSpiData[7];
        is_data   = bus.iSpiRecv & ~bus.iSpiData[7];
        push_req  = is_data & hdr_valid;
        frame_err = is_data & ~hdr_valid;
        empty     = (level == '0);
        full      = (level == LVL_W'(DEPTH));
        pop       = bus.iClkEn & ~empty;
        push      = push_req & (~full | pop);
        drop      = push_req & full & ~pop;
        wr_entry  = '{addr: hdr_addr, data: {hdr_msb, bus.iSpiData[5:0]}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_valid <= 1'b0;
            hdr_addr  <= '0;
            hdr_msb   <= '0;
        end else if (is_hdr) begin
            hdr_valid <= 1'b1;
            hdr_addr  <= bus.iSpiData[6:2];
            hdr_msb   <= bus.iSpiData[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wr_ptr] <= wr_entry;
    end

    // The output registers hold the last popped entry until the next pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q <= pop;
            if (pop) begin
                addr_q <= mem[rd_ptr].addr;
                data_q <= mem[rd_ptr].data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            if (drop)      ovf_q  <= 1'b1;
            if (frame_err) ferr_q <= 1'b1;
        end
    end

    assign bus.oWE       = we_q;
    assign bus.oAddr     = addr_q;
    assign bus.oDataW    = data_q;
    assign bus.oLevel    = level;
    assign bus.oOverflow = ovf_q;
    assign bus.oFrameErr = ferr_q;
endmodule

// File: tb/tb_sid_bus_queue.sv
// Bench for sid_bus_queue. A vector table covers the single-write and framing cases.
// Hand sequences cover burst, overflow, full-with-pop and reset; SID writes are checked against a scoreboard.
module tb_sid_bus_queue;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sid_bus_queue_if #(.LVL_W(5)) bus ();

    sid_bus_queue #(.DEPTH(16), .LVL_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        r;
        logic        recv;
        logic [7:0]  d;
        logic        ce;
        logic [4:0]  lvl;
        logic        we;
        logic        ovf;
        logic        ferr;
        logic        sb;
        logic [12:0] ew;
    } vec_t;

    vec_t        vecs [14];
    logic [12:0] sbq [$];
    int nvec = 0;
    int nerr = 0;
    int ph = 0;
    int cyc = 0;
    int rst_cyc = 0;
    int last_we = -1;

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock. Inputs are driven 1 time unit after the edge and outputs are read 1 time unit after the next edge.
    task automatic step(input logic r, input logic recv, input logic [7:0] d, input logic ce);
        rst          = r;
        bus.iSpiRecv = recv;
        bus.iSpiData = d;
        bus.iClkEn   = ce;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.iSpiRecv = 1'b0;
        bus.iClkEn   = 1'b0;
    endtask

    // Idle cycles with the SID enable firing once every 12 cycles.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 8'h00, ph == 11);
            ph = (ph == 11) ? 0 : ph + 1;
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) rst_cyc <= cyc;
    end

    always @(negedge clk) begin
        if (bus.oWE === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_we", 1, 0);
            end else begin
                logic [12:0] e;
                e = sbq.pop_front();
                chk("wr_addr", int'(bus.oAddr), int'(e[12:8]));
                chk("wr_data", int'(bus.oDataW), int'(e[7:0]));
            end
            if (last_we > rst_cyc) chk("we_spacing", int'((cyc - last_we) >= 12), 1);
            last_we = cyc;
        end
    end

    initial begin
        //             r  rv d      ce lvl we ovf ferr sb ew
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0};
        vecs[1]  = '{1'b0, 1'b1, 8'h85, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0};
        vecs[2]  = '{1'b0, 1'b1, 8'h2A, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, {5'd1, 8'h6A}};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0};
        vecs[6]  = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0};
        vecs[7]  = '{1'b0, 1'b1, 8'h2A, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 13'h0};
        vecs[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 13'h0};
        vecs[9]  = '{1'b0, 1'b1, 8'hFC, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 13'h0};
        vecs[10] = '{1'b0, 1'b1, 8'h3F, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 1'b1, {5'd31, 8'h3F}};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 13'h0};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 13'h0};
        vecs[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0};

        bus.iSpiData = 8'h00;
        bus.iSpiRecv = 1'b0;
        bus.iClkEn   = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].sb) sbq.push_back(vecs[i].ew);
            step(vecs[i].r, vecs[i].recv, vecs[i].d, vecs[i].ce);
            chk($sformatf("v%0d_lvl", i),  int'(bus.oLevel),    int'(vecs[i].lvl));
            chk($sformatf("v%0d_we", i),   int'(bus.oWE),       int'(vecs[i].we));
            chk($sformatf("v%0d_ovf", i),  int'(bus.oOverflow), int'(vecs[i].ovf));
            chk($sformatf("v%0d_ferr", i), int'(bus.oFrameErr), int'(vecs[i].ferr));
        end

        // Burst: one header followed by three back-to-back data bytes.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h85, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            sbq.push_back({5'd1, 8'(8'h40 + i)});
            step(1'b0, 1'b1, 8'(i), 1'b0);
        end
        chk("burst_lvl3", int'(bus.oLevel), 3);
        ph = 0;
        run(40);
        chk("burst_lvl0", int'(bus.oLevel), 0);
        chk("burst_drained", sbq.size(), 0);

        // Overflow: 17 bytes with the enable held low; the 17th byte must be dropped.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h85, 1'b0);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) sbq.push_back({5'd1, 8'(8'h40 + i)});
            step(1'b0, 1'b1, 8'(i), 1'b0);
        end
        chk("ovf_lvl16", int'(bus.oLevel), 16);
        chk("ovf_flag", int'(bus.oOverflow), 1);
        chk("ovf_ferr", int'(bus.oFrameErr), 0);
        ph = 0;
        run(16 * 12 + 12);
        chk("ovf_lvl0", int'(bus.oLevel), 0);
        chk("ovf_sticky", int'(bus.oOverflow), 1);
        chk("ovf_drained", sbq.size(), 0);

        // Full FIFO with a push on the same cycle as a pop.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h85, 1'b0);
        for (int i = 0; i < 16; i++) begin
            sbq.push_back({5'd1, 8'(8'h40 + i)});
            step(1'b0, 1'b1, 8'(i), 1'b0);
        end
        chk("fullpop_lvl16a", int'(bus.oLevel), 16);
        sbq.push_back({5'd1, 8'h55});
        step(1'b0, 1'b1, 8'h15, 1'b1);
        chk("fullpop_lvl16b", int'(bus.oLevel), 16);
        chk("fullpop_we", int'(bus.oWE), 1);
        chk("fullpop_ovf", int'(bus.oOverflow), 0);
        ph = 0;
        run(17 * 12);
        chk("fullpop_lvl0", int'(bus.oLevel), 0);
        chk("fullpop_drained", sbq.size(), 0);

        // Reset mid-stream with a header latched and entries pending.
        step(1'b1, 1'b0, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h22, 1'b0);
        step(1'b0, 1'b1, 8'h85, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
        chk("rst_pre_lvl", int'(bus.oLevel), 5);
        chk("rst_pre_ferr", int'(bus.oFrameErr), 1);
        step(1'b1, 1'b1, 8'h07, 1'b1);
        chk("rst_we", int'(bus.oWE), 0);
        chk("rst_lvl", int'(bus.oLevel), 0);
        chk("rst_ovf", int'(bus.oOverflow), 0);
        chk("rst_ferr", int'(bus.oFrameErr), 0);
        chk("rst_addr", int'(bus.oAddr), 0);
        chk("rst_data", int'(bus.oDataW), 0);
        step(1'b0, 1'b1, 8'h11, 1'b0);
        chk("rst_post_ferr", int'(bus.oFrameErr), 1);
        chk("rst_post_lvl", int'(bus.oLevel), 0);
        ph = 0;
        run(30);
        chk("rst_post_lvl_end", int'(bus.oLevel), 0);

        chk("sb_empty", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
